// File: rtl/core101_pkg.sv
// Core-wide constants shared by the fetch path: default widths, instruction size, reset vector.
package core101_pkg;

    localparam int unsigned CoreDataWidth = 32;
    localparam int unsigned CoreAddrWidth = 32;
    localparam int unsigned CoreInstBytes = 4;
    localparam logic [31:0] CoreResetAddr = 32'h0000_0000;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-unit buses: instruction-memory request/response channel and decode-facing queue head.
interface ifu_prefetch_if #(
    parameter int unsigned DATA_WIDTH = core101_pkg::CoreDataWidth,
    parameter int unsigned ADDR_WIDTH = core101_pkg::CoreAddrWidth
) ();

    logic                  mem_req_valid_out;
    logic                  mem_req_ready_in;
    logic [ADDR_WIDTH-1:0] mem_req_addr_out;
    logic                  mem_rsp_valid_in;
    logic [DATA_WIDTH-1:0] mem_rsp_data_in;
    logic                  ir_valid_out;
    logic                  ir_ready_in;
    logic [DATA_WIDTH-1:0] ir_data_out;
    logic [ADDR_WIDTH-1:0] ir_pc_out;

    modport master (
        output mem_req_valid_out, mem_req_addr_out, ir_valid_out, ir_data_out, ir_pc_out,
        input  mem_req_ready_in, mem_rsp_valid_in, mem_rsp_data_in, ir_ready_in
    );

    modport slave (
        input  mem_req_valid_out, mem_req_addr_out, ir_valid_out, ir_data_out, ir_pc_out,
        output mem_req_ready_in, mem_rsp_valid_in, mem_rsp_data_in, ir_ready_in
    );

endinterface

// File: rtl/ifu_fetch_queue.sv
// Synchronous FIFO with flush and occupancy output; head data reads as zero when empty.
module ifu_fetch_queue
    import core101_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && (cnt_q != '0);
        // A full queue accepts a push only when the head leaves in the same cycle.
        do_push = push_i && ((cnt_q != CntW'(DEPTH)) || do_pop);
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rdata_o = (cnt_q != '0) ? mem_q[rptr_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit: credit-limited sequential fetch feeding a decode queue.
// Define IFU_PERF_CNT_EN to add fetch/flush performance counter outputs.
module ifu_prefetch
    import core101_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = CoreDataWidth,
    parameter int unsigned           ADDR_WIDTH  = CoreAddrWidth,
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter int unsigned           INST_BYTES  = CoreInstBytes,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = ADDR_WIDTH'(CoreResetAddr)
) (
    input  logic                  ifu_clock_in,
    input  logic                  ifu_reset_in,
    input  logic                  redirect_valid_in,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_in,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]           perf_fetch_cnt_out,
    output logic [31:0]           perf_flush_cnt_out,
`endif
    ifu_prefetch_if.master        bus
);

    localparam int unsigned CntW = cnt_width(QUEUE_DEPTH);
    localparam int unsigned SumW = CntW + 1;
    localparam int unsigned EntW = DATA_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]       discard_q, discard_d;
    logic [CntW-1:0]       q_count, outstanding;
    logic [SumW-1:0]       credit_used;
    logic [EntW-1:0]       q_rdata;
    logic [ADDR_WIDTH-1:0] rsp_pc;
    logic                  req_valid, req_fire, rsp_fire, drop, live_push, ir_valid, deq;

    always_comb begin
        rsp_fire    = bus.mem_rsp_valid_in;
        credit_used = SumW'(q_count) + SumW'(outstanding);
        // Reserving a slot per in-flight request means responses never need backpressure.
        req_valid   = ifu_reset_in && !redirect_valid_in && (credit_used < SumW'(QUEUE_DEPTH));
        req_fire    = req_valid && bus.mem_req_ready_in;
        drop        = rsp_fire && (redirect_valid_in || (discard_q != '0));
        live_push   = rsp_fire && !drop;
        ir_valid    = (q_count != '0) && !redirect_valid_in;
        deq         = ir_valid && bus.ir_ready_in;

        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect_valid_in) begin
            fetch_pc_d = redirect_addr_in;
            // Everything still in flight after this cycle belongs to the old stream.
            discard_d  = outstanding - CntW'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INST_BYTES);
            end
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge ifu_clock_in or negedge ifu_reset_in) begin
        if (!ifu_reset_in) begin
            fetch_pc_q <= RESET_ADDR;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    // PC of each accepted request, popped by its response whether live or dropped.
    ifu_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_pc_fifo (
        .clk_i   (ifu_clock_in),
        .rst_ni  (ifu_reset_in),
        .push_i  (req_fire),
        .wdata_i (fetch_pc_q),
        .pop_i   (rsp_fire),
        .flush_i (1'b0),
        .rdata_o (rsp_pc),
        .count_o (outstanding)
    );

    ifu_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EntW)
    ) u_inst_queue (
        .clk_i   (ifu_clock_in),
        .rst_ni  (ifu_reset_in),
        .push_i  (live_push),
        .wdata_i ({bus.mem_rsp_data_in, rsp_pc}),
        .pop_i   (deq),
        .flush_i (redirect_valid_in),
        .rdata_o (q_rdata),
        .count_o (q_count)
    );

    assign bus.mem_req_valid_out = req_valid;
    assign bus.mem_req_addr_out  = fetch_pc_q;
    assign bus.ir_valid_out      = ir_valid;
    assign bus.ir_data_out       = q_rdata[EntW-1:ADDR_WIDTH];
    assign bus.ir_pc_out         = q_rdata[ADDR_WIDTH-1:0];

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(live_push);
        flush_cnt_d = flush_cnt_q + 32'(redirect_valid_in);
    end

    always_ff @(posedge ifu_clock_in or negedge ifu_reset_in) begin
        if (!ifu_reset_in) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt_out = fetch_cnt_q;
    assign perf_flush_cnt_out = flush_cnt_q;
`endif

endmodule
